// File: rtl/music_box_state_controller_if.sv
// music_box_state_controller_if: request/abort/done inputs and state outputs of the music box sequencer
//   request[3:0], abort, state_done[4:0] : driven by the master (buttons / state modules)
//   currentState, state_entered, timeout_flag, busy, debugString : driven by the controller (slave)
interface music_box_state_controller_if;
   logic [3:0]  request;
   logic        abort;
   logic [4:0]  state_done;
   logic [4:0]  currentState;
   logic        state_entered;
   logic        timeout_flag;
   logic        busy;
   logic [31:0] debugString;
   modport master (
      output request, abort, state_done,
      input  currentState, state_entered, timeout_flag, busy, debugString
   );
   modport slave (
      input  request, abort, state_done,
      output currentState, state_entered, timeout_flag, busy, debugString
   );
endinterface

// File: rtl/music_box_state_controller.sv
// music_box_state_controller: arbitrates button requests into currentState, returns on done/timeout/abort, guards re-grant
//   clock_50Mhz, reset : single clock, synchronous active-high reset
//   bus (slave)        : request/abort/state_done in; currentState, state_entered, timeout_flag, busy, debugString out
module music_box_state_controller #(
   parameter int TICK_DIV   = 50000,
   parameter int TIMEOUT_MS = 6000,
   parameter int GUARD_MS   = 200
) (
   input logic clock_50Mhz,
   input logic reset,
   music_box_state_controller_if.slave bus
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);
   localparam logic [15:0] GUARD_LAST = 16'(GUARD_MS - 1);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state;
   logic [PW-1:0] prescaler;
   logic [3:0] req_q, pending, edges;
   logic [15:0] ms_count, ms_inc;
   logic [4:0] cur;
   logic [2:0] grant;
   logic guard_done, tick, done_hit, timeout_hit, entered, tflag, busy_q;
   // lowest set pending bit wins; state code is bit index + 1
   always_comb grant = pending[0] ? 3'd1 : pending[1] ? 3'd2 : pending[2] ? 3'd3 : 3'd4;
   assign tick = prescaler == PW'(TICK_DIV - 1);
   assign edges = bus.request & ~req_q;
   // saturating millisecond count, advanced only on tick
   assign ms_inc = tick && ms_count != 16'hFFFF ? ms_count + 16'd1 : ms_count;
   assign done_hit = bus.state_done[cur[2:0]];
   assign timeout_hit = tick && ms_count == TIMEOUT_LAST;
   assign bus.currentState = cur;
   assign bus.state_entered = entered;
   assign bus.timeout_flag = tflag;
   assign bus.busy = busy_q;
   assign bus.debugString = {pending, 3'b0, cur, ms_count, 4'b0};
   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         state      <= IDLE;
         cur        <= '0;
         entered    <= 1'b0;
         tflag      <= 1'b0;
         busy_q     <= 1'b0;
         pending    <= '0;
         prescaler  <= '0;
         ms_count   <= '0;
         guard_done <= 1'b1;
         req_q      <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         req_q     <= bus.request;
         entered   <= 1'b0;
         if (state == IDLE) begin
            if (!bus.abort && guard_done && |pending) begin
               // edges arriving in the grant cycle are intentionally dropped
               state    <= ACTIVE;
               cur      <= {2'b0, grant};
               pending  <= '0;
               ms_count <= '0;
               tflag    <= 1'b0;
               entered  <= 1'b1;
               busy_q   <= 1'b1;
            end else begin
               pending  <= bus.abort ? '0 : pending | edges;
               ms_count <= ms_inc;
               if (tick && ms_count == GUARD_LAST) guard_done <= 1'b1;
            end
         end else begin
            pending <= '0;
            if (bus.abort || done_hit || timeout_hit) begin
               state      <= IDLE;
               cur        <= '0;
               busy_q     <= 1'b0;
               ms_count   <= '0;
               guard_done <= (GUARD_MS == 0);
               // only a pure timeout return sets the flag; abort and done take priority
               if (!bus.abort && !done_hit) tflag <= 1'b1;
            end else begin
               ms_count <= ms_inc;
            end
         end
      end
   end
endmodule

// File: tb/tb_music_box_state_controller.sv
// tb_music_box_state_controller: directed checks of grant, done, timeout, arbitration, guard, abort and reset
module tb_music_box_state_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int tests = 0;
   int failed = 0;
   music_box_state_controller_if bus();
   music_box_state_controller #(.TICK_DIV(4), .TIMEOUT_MS(10), .GUARD_MS(2)) dut (
      .clock_50Mhz(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // cyc equals the number of edges since the last reset edge, so the prescaler ticks when cyc%4==3
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic go(input int target);
      while (cyc < target) step();
   endtask
   task automatic test_reset();
      bus.request = 4'b0;
      bus.abort = 1'b0;
      bus.state_done = 5'b0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL reset_state got %0d want 0", bus.currentState); end
      tests++; if (bus.state_entered !== 1'b0) begin failed++; $display("FAIL reset_entered got %b want 0", bus.state_entered); end
      tests++; if (bus.timeout_flag !== 1'b0) begin failed++; $display("FAIL reset_timeout got %b want 0", bus.timeout_flag); end
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      tests++; if (bus.debugString !== 32'h0) begin failed++; $display("FAIL reset_debug got %h want 0", bus.debugString); end
   endtask
   task automatic test_grant();
      go(5);
      bus.request = 4'b1000;
      step();
      tests++; if (bus.debugString[31:28] !== 4'b1000) begin failed++; $display("FAIL grant_pending got %b want 1000", bus.debugString[31:28]); end
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL grant_early got %0d want 0", bus.currentState); end
      bus.request = 4'b0;
      step();
      tests++; if (bus.currentState !== 5'd4) begin failed++; $display("FAIL grant_state got %0d want 4", bus.currentState); end
      tests++; if (bus.state_entered !== 1'b1) begin failed++; $display("FAIL grant_entered got %b want 1", bus.state_entered); end
      tests++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL grant_busy got %b want 1", bus.busy); end
      step();
      tests++; if (bus.state_entered !== 1'b0) begin failed++; $display("FAIL grant_pulse got %b want 0", bus.state_entered); end
      tests++; if (bus.currentState !== 5'd4) begin failed++; $display("FAIL grant_hold got %0d want 4", bus.currentState); end
   endtask
   task automatic test_done();
      bus.state_done = 5'b00100;
      step();
      bus.state_done = 5'b0;
      tests++; if (bus.currentState !== 5'd4) begin failed++; $display("FAIL done_other got %0d want 4", bus.currentState); end
      go(27);
      tests++; if (bus.debugString[19:4] !== 16'd5) begin failed++; $display("FAIL done_ms got %0d want 5", bus.debugString[19:4]); end
      bus.state_done = 5'b10000;
      step();
      bus.state_done = 5'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL done_return got %0d want 0", bus.currentState); end
      tests++; if (bus.timeout_flag !== 1'b0) begin failed++; $display("FAIL done_timeout got %b want 0", bus.timeout_flag); end
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL done_busy got %b want 0", bus.busy); end
   endtask
   task automatic test_timeout();
      go(38);
      bus.request = 4'b0001;
      step();
      bus.request = 4'b0;
      step();
      tests++; if (bus.currentState !== 5'd1) begin failed++; $display("FAIL to_grant got %0d want 1", bus.currentState); end
      go(79);
      tests++; if (bus.currentState !== 5'd1) begin failed++; $display("FAIL to_before got %0d want 1", bus.currentState); end
      tests++; if (bus.debugString[19:4] !== 16'd9) begin failed++; $display("FAIL to_ms got %0d want 9", bus.debugString[19:4]); end
      step();
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL to_return got %0d want 0", bus.currentState); end
      tests++; if (bus.timeout_flag !== 1'b1) begin failed++; $display("FAIL to_flag got %b want 1", bus.timeout_flag); end
   endtask
   task automatic test_arbitration();
      bus.request = 4'b0110;
      step();
      go(88);
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL arb_guard got %0d want 0", bus.currentState); end
      tests++; if (bus.debugString[31:28] !== 4'b0110) begin failed++; $display("FAIL arb_pending got %b want 0110", bus.debugString[31:28]); end
      tests++; if (bus.timeout_flag !== 1'b1) begin failed++; $display("FAIL arb_flag_held got %b want 1", bus.timeout_flag); end
      step();
      tests++; if (bus.currentState !== 5'd2) begin failed++; $display("FAIL arb_state got %0d want 2", bus.currentState); end
      tests++; if (bus.timeout_flag !== 1'b0) begin failed++; $display("FAIL arb_flag_clear got %b want 0", bus.timeout_flag); end
      bus.request = 4'b0;
      step();
      bus.request = 4'b0001;
      step();
      tests++; if (bus.debugString[31:28] !== 4'b0) begin failed++; $display("FAIL arb_drop got %b want 0000", bus.debugString[31:28]); end
      go(92);
      bus.state_done = 5'b00100;
      step();
      bus.state_done = 5'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL arb_return got %0d want 0", bus.currentState); end
      go(110);
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL arb_no_regrant got %0d want 0", bus.currentState); end
      tests++; if (bus.debugString[31:28] !== 4'b0) begin failed++; $display("FAIL arb_level got %b want 0000", bus.debugString[31:28]); end
      bus.request = 4'b0;
   endtask
   task automatic test_guard();
      go(111);
      bus.request = 4'b0100;
      step();
      bus.request = 4'b0;
      step();
      tests++; if (bus.currentState !== 5'd3) begin failed++; $display("FAIL guard_enter got %0d want 3", bus.currentState); end
      go(116);
      bus.state_done = 5'b01000;
      step();
      bus.state_done = 5'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL guard_return got %0d want 0", bus.currentState); end
      step();
      bus.request = 4'b0001;
      step();
      bus.request = 4'b0;
      go(124);
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL guard_wait got %0d want 0", bus.currentState); end
      tests++; if (bus.debugString[31:28] !== 4'b0001) begin failed++; $display("FAIL guard_pending got %b want 0001", bus.debugString[31:28]); end
      step();
      tests++; if (bus.currentState !== 5'd1) begin failed++; $display("FAIL guard_grant got %0d want 1", bus.currentState); end
   endtask
   task automatic test_abort();
      go(163);
      tests++; if (bus.debugString[19:4] !== 16'd9) begin failed++; $display("FAIL abort_ms got %0d want 9", bus.debugString[19:4]); end
      bus.abort = 1'b1;
      bus.state_done = 5'b00010;
      step();
      bus.state_done = 5'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL abort_return got %0d want 0", bus.currentState); end
      tests++; if (bus.timeout_flag !== 1'b0) begin failed++; $display("FAIL abort_flag got %b want 0", bus.timeout_flag); end
      bus.request = 4'b0010;
      step();
      bus.request = 4'b0;
      step();
      tests++; if (bus.debugString[31:28] !== 4'b0) begin failed++; $display("FAIL abort_pending got %b want 0000", bus.debugString[31:28]); end
      go(175);
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL abort_hold got %0d want 0", bus.currentState); end
      bus.abort = 1'b0;
      go(180);
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL abort_release got %0d want 0", bus.currentState); end
   endtask
   task automatic test_reset_mid();
      bus.request = 4'b1000;
      step();
      bus.request = 4'b0;
      step();
      tests++; if (bus.currentState !== 5'd4) begin failed++; $display("FAIL mid_enter got %0d want 4", bus.currentState); end
      go(185);
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++; if (bus.currentState !== 5'd0) begin failed++; $display("FAIL mid_state got %0d want 0", bus.currentState); end
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL mid_busy got %b want 0", bus.busy); end
      tests++; if (bus.state_entered !== 1'b0) begin failed++; $display("FAIL mid_entered got %b want 0", bus.state_entered); end
      tests++; if (bus.timeout_flag !== 1'b0) begin failed++; $display("FAIL mid_flag got %b want 0", bus.timeout_flag); end
      tests++; if (bus.debugString !== 32'h0) begin failed++; $display("FAIL mid_debug got %h want 0", bus.debugString); end
   endtask
   initial begin
      test_reset();
      test_grant();
      test_done();
      test_timeout();
      test_arbitration();
      test_guard();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
